filter_pos: RTL

Downstream consumer of the position-calculation stage. Takes the 32-bit signed position word the calc block produces, plus an enable and a trigger. On each trigger it reports either the change in position since the previous trigger or the truncated mean of all positions sampled in the window. The result is presented as a 32-bit position word with a one-cycle ready pulse, for capture or compare stages further downstream.

---
 rtl/filter_pkg.sv | 22 ++
 rtl/filter_divider.sv | 91 +++++++++
 rtl/filter_pos.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared widths, codes and divider state type for the position filter.
package filter_pkg;

  localparam int unsigned POS_W    = 32;
  localparam int unsigned ACC_W    = 64;
  localparam int unsigned DIV_ITER = 64;
  localparam int unsigned ITER_W   = $clog2(DIV_ITER);

  localparam logic MODE_DIFF = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

  localparam logic [1:0] HEALTH_OK   = 2'd0;
  localparam logic [1:0] HEALTH_SAT  = 2'd1;
  localparam logic [1:0] HEALTH_BUSY = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } div_state_e;

endpackage

// File: rtl/filter_divider.sv
// Unsigned ACC_W / POS_W restoring divider, one quotient bit per cycle.
// Latency from start to done is DIV_ITER + 1 cycles.
module filter_divider
  import filter_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [ACC_W-1:0] dividend_i,
  input  logic [POS_W-1:0] divisor_i,
  output logic [ACC_W-1:0] quotient_o,
  output logic             done_o,
  output logic             busy_o
);

  div_state_e       state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic [POS_W-1:0] rem_q, rem_d;
  logic [POS_W-1:0] dsr_q, dsr_d;
  logic [POS_W:0]   rem_sh;
  logic [POS_W:0]   rem_sub;
  logic             unused_sub_msb;

  // Next-state: load operands on start, then shift/subtract once per RUN cycle.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    // Remainder stays below the divisor, so one extra bit holds the shifted value.
    rem_sh  = {rem_q, quo_q[ACC_W-1]};
    rem_sub = rem_sh - {1'b0, dsr_q};
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          iter_d  = '0;
          quo_d   = dividend_i;
          rem_d   = '0;
          dsr_d   = divisor_i;
        end
      end
      StRun: begin
        if (rem_sh >= {1'b0, dsr_q}) begin
          rem_d = rem_sub[POS_W-1:0];
          quo_d = {quo_q[ACC_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[POS_W-1:0];
          quo_d = {quo_q[ACC_W-2:0], 1'b0};
        end
        if (iter_q == ITER_W'(DIV_ITER - 1)) begin
          state_d = StDone;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i) begin
      state_d = StIdle;
    end
  end

  assign unused_sub_msb = rem_sub[POS_W];

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      iter_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dsr_q   <= dsr_d;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = (state_q == StDone);
  assign busy_o     = (state_q != StIdle);

endmodule

// File: rtl/filter_pos.sv
// Position filter: per trigger, reports either the position delta since the
// previous trigger or the truncated mean of the samples in the current window.
module filter_pos
  import filter_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             trig_i,
  input  logic [POS_W-1:0] inp_i,
  input  logic             MODE,
  output logic [POS_W-1:0] out_o,
  output logic             ready_o,
  output logic [1:0]       health_o
);

  localparam logic [POS_W-1:0] CntMax = '1;

  logic             en_q, trig_q;
  logic [POS_W-1:0] ref_q, ref_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [POS_W-1:0] count_q, count_d;
  logic [POS_W-1:0] out_q, out_d;
  logic             ready_q, ready_d;
  logic [1:0]       health_q, health_d;
  logic             neg_q, neg_d;

  logic             en_rise, en_fall, trig_rise;
  logic             accumulate;
  logic [ACC_W-1:0] inp_ext, snap_sum, div_dividend, div_quot;
  logic [POS_W-1:0] snap_cnt, avg_res;
  logic             div_start, div_abort, div_done, div_busy, avg_valid;
  logic             unused_quot_hi;

  assign en_rise   = enable_i & ~en_q;
  assign en_fall   = ~enable_i & en_q;
  assign trig_rise = trig_i & ~trig_q;
  assign div_abort = en_rise | en_fall;
  // A division finishing in a disabled cycle is dropped.
  assign avg_valid = div_done & enable_i;

  // Window accumulation, difference path, snapshot/divider start and health.
  always_comb begin
    ref_d        = ref_q;
    sum_d        = sum_q;
    count_d      = count_q;
    out_d        = out_q;
    ready_d      = 1'b0;
    health_d     = health_q;
    neg_d        = neg_q;
    accumulate   = 1'b0;
    div_start    = 1'b0;
    inp_ext      = {{(ACC_W - POS_W){inp_i[POS_W-1]}}, inp_i};
    snap_sum     = sum_q + inp_ext;
    snap_cnt     = (count_q == CntMax) ? CntMax : count_q + 1'b1;
    // Divide the magnitude; sign is restored on the quotient.
    div_dividend = snap_sum[ACC_W-1] ? -snap_sum : snap_sum;
    avg_res      = neg_q ? -div_quot[POS_W-1:0] : div_quot[POS_W-1:0];

    // Latch the mean so out_o holds it after the ready cycle.
    if (avg_valid) begin
      out_d = avg_res;
    end

    if (en_rise) begin
      ref_d    = inp_i;
      sum_d    = inp_ext;
      count_d  = {{(POS_W - 1){1'b0}}, 1'b1};
      health_d = HEALTH_OK;
    end else if (enable_i) begin
      accumulate = 1'b1;
      if (trig_rise) begin
        if (MODE == MODE_DIFF) begin
          out_d   = inp_i - ref_q;
          ref_d   = inp_i;
          ready_d = 1'b1;
        end else if (div_busy) begin
          health_d = HEALTH_BUSY;
        end else begin
          div_start  = 1'b1;
          neg_d      = snap_sum[ACC_W-1];
          sum_d      = '0;
          count_d    = '0;
          accumulate = 1'b0;
        end
      end
    end

    if (accumulate) begin
      sum_d   = sum_q + inp_ext;
      count_d = snap_cnt;
      if (snap_cnt == CntMax && health_d != HEALTH_BUSY) begin
        health_d = HEALTH_SAT;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en_q     <= 1'b0;
      trig_q   <= 1'b0;
      ref_q    <= '0;
      sum_q    <= '0;
      count_q  <= '0;
      out_q    <= '0;
      ready_q  <= 1'b0;
      health_q <= HEALTH_OK;
      neg_q    <= 1'b0;
    end else begin
      en_q     <= enable_i;
      trig_q   <= trig_i;
      ref_q    <= ref_d;
      sum_q    <= sum_d;
      count_q  <= count_d;
      out_q    <= out_d;
      ready_q  <= ready_d;
      health_q <= health_d;
      neg_q    <= neg_d;
    end
  end

  filter_divider u_divider (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (div_start),
    .abort_i    (div_abort),
    .dividend_i (div_dividend),
    .divisor_i  (snap_cnt),
    .quotient_o (div_quot),
    .done_o     (div_done),
    .busy_o     (div_busy)
  );

  assign unused_quot_hi = ^div_quot[ACC_W-1:POS_W];

  assign out_o    = avg_valid ? avg_res : out_q;
  assign ready_o  = ready_q | avg_valid;
  assign health_o = health_q;

endmodule
